// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared types and defaults for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

    // Sequencer state encoding.
    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_e;

    // Per-cycle arbitration result, highest priority first.
    typedef enum logic [2:0] {
        PRIO_MEM_BUSY  = 3'd0,
        PRIO_BRANCH    = 3'd1,
        PRIO_FLUSH_WIN = 3'd2,
        PRIO_LOAD_USE  = 3'd3,
        PRIO_JUMP      = 3'd4,
        PRIO_NONE      = 3'd5
    } prio_e;

    // Defaults, reused by the MIPS top-level wrapper.
    localparam int unsigned DEFAULT_FLUSH_CYCLES = 1;
    localparam int unsigned DEFAULT_MEM_TIMEOUT  = 64;
    localparam int unsigned DEFAULT_CNT_W        = 16;

    localparam int unsigned FLUSH_LEFT_W = 3;
    localparam int unsigned WAIT_CNT_W   = 10;

endpackage

// File: rtl/pipeline_stall_ctrl_if.sv
// Request/control bundle between the pipeline datapath and the stall sequencer.
interface pipeline_stall_ctrl_if
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = DEFAULT_CNT_W
);
    // Hazard / redirect / memory requests
    logic             load_use;
    logic             jump;
    logic             branch_taken;
    logic             mem_busy;
    logic             cnt_clr;
    // Pipeline register controls
    logic             pc_write;
    logic             ifid_write;
    logic             ifid_flush;
    logic             idex_write;
    logic             idex_bubble;
    logic             idex_flush;
    logic             exmem_write;
    logic             memwb_write;
    // Status
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_events;

    // Datapath side: raises requests, consumes controls.
    modport master (
        output load_use, jump, branch_taken, mem_busy, cnt_clr,
        input  pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, idex_flush,
        input  exmem_write, memwb_write, mem_timeout, stall_cycles, flush_events
    );

    // Sequencer side.
    modport slave (
        input  load_use, jump, branch_taken, mem_busy, cnt_clr,
        output pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, idex_flush,
        output exmem_write, memwb_write, mem_timeout, stall_cycles, flush_events
    );

endinterface

// File: rtl/pipeline_stall_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
module sat_counter
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned W = DEFAULT_CNT_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_count
);

    logic [W-1:0] r_count;

    // Count register: clear, else increment until all-ones.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Central stall/flush sequencer for the 5-stage MIPS pipeline.
module pipeline_stall_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = DEFAULT_FLUSH_CYCLES,
    parameter int unsigned MEM_TIMEOUT  = DEFAULT_MEM_TIMEOUT,
    parameter int unsigned CNT_W        = DEFAULT_CNT_W
) (
    input  logic                 clk,
    input  logic                 reset,
    pipeline_stall_ctrl_if.slave bus
);

    localparam logic [FLUSH_LEFT_W-1:0] FLUSH_RELOAD = FLUSH_LEFT_W'(FLUSH_CYCLES - 1);
    localparam logic [WAIT_CNT_W-1:0]   WAIT_LIMIT   = WAIT_CNT_W'(MEM_TIMEOUT - 1);

    logic                    r_run_en;
    state_e                  r_state;
    state_e                  w_state_nxt;
    logic [FLUSH_LEFT_W-1:0] r_flush_left;
    logic [FLUSH_LEFT_W-1:0] w_flush_left_nxt;
    logic [WAIT_CNT_W-1:0]   r_wait_cnt;
    logic [WAIT_CNT_W-1:0]   w_wait_cnt_nxt;
    logic                    r_timeout;
    logic                    w_timeout_nxt;
    prio_e                   w_prio;
    logic                    w_flush_evt;
    logic                    w_pc_write;
    logic                    w_ifid_write;
    logic                    w_ifid_flush;
    logic                    w_idex_write;
    logic                    w_idex_bubble;
    logic                    w_idex_flush;
    logic                    w_exmem_write;
    logic                    w_memwb_write;

    // Fixed-priority arbitration of this cycle's events.
    always_comb begin
        w_prio = PRIO_NONE;
        if (bus.mem_busy) begin
            w_prio = PRIO_MEM_BUSY;
        end else if (bus.branch_taken) begin
            w_prio = PRIO_BRANCH;
        end else if (r_state == FLUSH) begin
            w_prio = PRIO_FLUSH_WIN;
        end else if (bus.load_use) begin
            w_prio = PRIO_LOAD_USE;
        end else if (bus.jump) begin
            w_prio = PRIO_JUMP;
        end
    end

    // Next state and pipeline controls; everything stays 0 until run_en is set.
    always_comb begin
        w_state_nxt      = r_state;
        w_flush_left_nxt = r_flush_left;
        w_flush_evt      = 1'b0;
        w_pc_write       = 1'b0;
        w_ifid_write     = 1'b0;
        w_ifid_flush     = 1'b0;
        w_idex_write     = 1'b0;
        w_idex_bubble    = 1'b0;
        w_idex_flush     = 1'b0;
        w_exmem_write    = 1'b0;
        w_memwb_write    = 1'b0;
        if (r_run_en) begin
            unique case (w_prio)
                // Memory freeze: state and flush_left are simply held.
                PRIO_MEM_BUSY: ;
                PRIO_BRANCH: begin
                    {w_pc_write, w_ifid_write, w_idex_write} = 3'b111;
                    {w_exmem_write, w_memwb_write}           = 2'b11;
                    w_ifid_flush = 1'b1;
                    w_idex_flush = 1'b1;
                    w_flush_evt  = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        w_state_nxt      = FLUSH;
                        w_flush_left_nxt = FLUSH_RELOAD;
                    end else begin
                        w_state_nxt      = RUN;
                        w_flush_left_nxt = '0;
                    end
                end
                PRIO_FLUSH_WIN: begin
                    {w_pc_write, w_ifid_write, w_idex_write} = 3'b111;
                    {w_exmem_write, w_memwb_write}           = 2'b11;
                    w_ifid_flush     = 1'b1;
                    w_flush_left_nxt = r_flush_left - 1'b1;
                    if (r_flush_left <= 1) begin
                        w_state_nxt      = RUN;
                        w_flush_left_nxt = '0;
                    end
                end
                // Hold PC and IF/ID; a pending jump stays in ID and is taken later.
                PRIO_LOAD_USE: begin
                    {w_idex_write, w_exmem_write, w_memwb_write} = 3'b111;
                    w_idex_bubble = 1'b1;
                end
                PRIO_JUMP: begin
                    {w_pc_write, w_ifid_write, w_idex_write} = 3'b111;
                    {w_exmem_write, w_memwb_write}           = 2'b11;
                    w_ifid_flush = 1'b1;
                    w_flush_evt  = 1'b1;
                end
                PRIO_NONE: begin
                    {w_pc_write, w_ifid_write, w_idex_write} = 3'b111;
                    {w_exmem_write, w_memwb_write}           = 2'b11;
                end
                default: ;
            endcase
        end
    end

    // Memory-wait watchdog: saturating busy counter and sticky timeout flag.
    always_comb begin
        w_wait_cnt_nxt = r_wait_cnt;
        if (!bus.mem_busy) begin
            w_wait_cnt_nxt = '0;
        end else if (r_wait_cnt != '1) begin
            w_wait_cnt_nxt = r_wait_cnt + 1'b1;
        end
        w_timeout_nxt = r_timeout;
        if (bus.cnt_clr) begin
            w_timeout_nxt = 1'b0;
        end else if (bus.mem_busy && (r_wait_cnt == WAIT_LIMIT)) begin
            w_timeout_nxt = 1'b1;
        end
    end

    // State registers; reset drops any pending flush window immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_run_en     <= 1'b0;
            r_state      <= RUN;
            r_flush_left <= '0;
            r_wait_cnt   <= '0;
            r_timeout    <= 1'b0;
        end else begin
            r_run_en     <= 1'b1;
            r_state      <= w_state_nxt;
            r_flush_left <= w_flush_left_nxt;
            r_wait_cnt   <= w_wait_cnt_nxt;
            r_timeout    <= w_timeout_nxt;
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk     (clk),
        .reset   (reset),
        .i_clr   (bus.cnt_clr),
        .i_inc   (r_run_en && !w_pc_write),
        .o_count (bus.stall_cycles)
    );

    sat_counter #(
        .W (CNT_W)
    ) u_flush_cnt (
        .clk     (clk),
        .reset   (reset),
        .i_clr   (bus.cnt_clr),
        .i_inc   (w_flush_evt),
        .o_count (bus.flush_events)
    );

    assign bus.pc_write    = w_pc_write;
    assign bus.ifid_write  = w_ifid_write;
    assign bus.ifid_flush  = w_ifid_flush;
    assign bus.idex_write  = w_idex_write;
    assign bus.idex_bubble = w_idex_bubble;
    assign bus.idex_flush  = w_idex_flush;
    assign bus.exmem_write = w_exmem_write;
    assign bus.memwb_write = w_memwb_write;
    assign bus.mem_timeout = r_timeout;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed bench for pipeline_stall_ctrl (FLUSH_CYCLES=3, MEM_TIMEOUT=4, CNT_W=4).
module tb_pipeline_stall_ctrl;
    import pipe_ctrl_pkg::*;

    // Control vector bit order: pc_write, ifid_write, ifid_flush, idex_write,
    // idex_bubble, idex_flush, exmem_write, memwb_write.
    localparam logic [7:0] CTL_OFF  = 8'h00;
    localparam logic [7:0] CTL_RUN  = 8'hD3;
    localparam logic [7:0] CTL_LU   = 8'h1B;
    localparam logic [7:0] CTL_BR   = 8'hF7;
    localparam logic [7:0] CTL_IFFL = 8'hF3;

    logic clk;
    logic reset;
    int   n_pass;
    int   n_total;

    pipeline_stall_ctrl_if #(.CNT_W(4)) bus ();

    pipeline_stall_ctrl #(
        .FLUSH_CYCLES (3),
        .MEM_TIMEOUT  (4),
        .CNT_W        (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [7:0] w_ctl;
    assign w_ctl = {bus.pc_write, bus.ifid_write, bus.ifid_flush, bus.idex_write,
                    bus.idex_bubble, bus.idex_flush, bus.exmem_write, bus.memwb_write};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_counters();
        bus.cnt_clr = 1'b1;
        tick();
        bus.cnt_clr = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        n_total++;
        if (w_ctl !== CTL_OFF) $display("FAIL reset_first_cycle: ctl=%h want %h", w_ctl, CTL_OFF);
        else n_pass++;
        n_total++;
        if (bus.stall_cycles !== 4'd0 || bus.flush_events !== 4'd0 || bus.mem_timeout !== 1'b0)
            $display("FAIL reset_counters: stall=%0d flush=%0d tmo=%b want 0 0 0",
                     bus.stall_cycles, bus.flush_events, bus.mem_timeout);
        else n_pass++;
        tick();
        n_total++;
        if (w_ctl !== CTL_RUN) $display("FAIL reset_run: ctl=%h want %h", w_ctl, CTL_RUN);
        else n_pass++;
        n_total++;
        if (bus.stall_cycles !== 4'd0) $display("FAIL reset_stall: got %0d want 0", bus.stall_cycles);
        else n_pass++;
    endtask

    task automatic test_load_use();
        bus.load_use = 1'b1;
        #1;
        n_total++;
        if (w_ctl !== CTL_LU) $display("FAIL lu_stall: ctl=%h want %h", w_ctl, CTL_LU);
        else n_pass++;
        tick();
        bus.load_use = 1'b0;
        #1;
        n_total++;
        if (w_ctl !== CTL_RUN) $display("FAIL lu_after: ctl=%h want %h", w_ctl, CTL_RUN);
        else n_pass++;
        n_total++;
        if (bus.stall_cycles !== 4'd1) $display("FAIL lu_count: got %0d want 1", bus.stall_cycles);
        else n_pass++;
    endtask

    task automatic test_branch();
        clr_counters();
        bus.branch_taken = 1'b1;
        #1;
        n_total++;
        if (w_ctl !== CTL_BR) $display("FAIL br_c0: ctl=%h want %h", w_ctl, CTL_BR);
        else n_pass++;
        tick();
        bus.branch_taken = 1'b0;
        bus.load_use     = 1'b1;
        for (int c = 1; c <= 2; c++) begin
            #1;
            n_total++;
            if (w_ctl !== CTL_IFFL) $display("FAIL br_c%0d: ctl=%h want %h", c, w_ctl, CTL_IFFL);
            else n_pass++;
            tick();
        end
        bus.load_use = 1'b0;
        #1;
        n_total++;
        if (w_ctl !== CTL_RUN) $display("FAIL br_c3: ctl=%h want %h", w_ctl, CTL_RUN);
        else n_pass++;
        n_total++;
        if (bus.flush_events !== 4'd1 || bus.stall_cycles !== 4'd0)
            $display("FAIL br_counts: flush=%0d stall=%0d want 1 0",
                     bus.flush_events, bus.stall_cycles);
        else n_pass++;
    endtask

    task automatic test_branch_restart();
        clr_counters();
        bus.branch_taken = 1'b1;
        tick();
        #1;
        n_total++;
        if (w_ctl !== CTL_BR) $display("FAIL rst_br2: ctl=%h want %h", w_ctl, CTL_BR);
        else n_pass++;
        tick();
        bus.branch_taken = 1'b0;
        for (int c = 1; c <= 2; c++) begin
            #1;
            n_total++;
            if (w_ctl !== CTL_IFFL) $display("FAIL rst_win%0d: ctl=%h want %h", c, w_ctl, CTL_IFFL);
            else n_pass++;
            tick();
        end
        #1;
        n_total++;
        if (w_ctl !== CTL_RUN || bus.flush_events !== 4'd2)
            $display("FAIL rst_end: ctl=%h flush=%0d want %h 2", w_ctl, bus.flush_events, CTL_RUN);
        else n_pass++;
    endtask

    task automatic test_mem_freeze();
        clr_counters();
        bus.branch_taken = 1'b1;
        tick();
        bus.branch_taken = 1'b0;
        tick();
        // Now in the last flush cycle (flush_left=1).
        bus.mem_busy = 1'b1;
        bus.load_use = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            n_total++;
            if (w_ctl !== CTL_OFF) $display("FAIL mf_busy%0d: ctl=%h want %h", c, w_ctl, CTL_OFF);
            else n_pass++;
            tick();
        end
        bus.mem_busy = 1'b0;
        bus.load_use = 1'b0;
        #1;
        n_total++;
        if (w_ctl !== CTL_IFFL) $display("FAIL mf_resume: ctl=%h want %h", w_ctl, CTL_IFFL);
        else n_pass++;
        tick();
        #1;
        n_total++;
        if (w_ctl !== CTL_RUN) $display("FAIL mf_run: ctl=%h want %h", w_ctl, CTL_RUN);
        else n_pass++;
        n_total++;
        if (bus.stall_cycles !== 4'd5) $display("FAIL mf_stall: got %0d want 5", bus.stall_cycles);
        else n_pass++;
    endtask

    task automatic test_watchdog();
        clr_counters();
        bus.mem_busy = 1'b1;
        repeat (3) tick();
        n_total++;
        if (bus.mem_timeout !== 1'b0) $display("FAIL wd_early: got %b want 0", bus.mem_timeout);
        else n_pass++;
        tick();
        n_total++;
        if (bus.mem_timeout !== 1'b1) $display("FAIL wd_fire: got %b want 1", bus.mem_timeout);
        else n_pass++;
        bus.mem_busy = 1'b0;
        tick();
        n_total++;
        if (bus.mem_timeout !== 1'b1 || bus.stall_cycles !== 4'd4)
            $display("FAIL wd_sticky: tmo=%b stall=%0d want 1 4", bus.mem_timeout, bus.stall_cycles);
        else n_pass++;
        clr_counters();
        n_total++;
        if (bus.mem_timeout !== 1'b0 || bus.stall_cycles !== 4'd0 || bus.flush_events !== 4'd0)
            $display("FAIL wd_clr: tmo=%b stall=%0d flush=%0d want 0 0 0",
                     bus.mem_timeout, bus.stall_cycles, bus.flush_events);
        else n_pass++;
    endtask

    task automatic test_priority_sat();
        bus.load_use = 1'b1;
        bus.jump     = 1'b1;
        #1;
        n_total++;
        if (w_ctl !== CTL_LU) $display("FAIL pr_lu_jump: ctl=%h want %h", w_ctl, CTL_LU);
        else n_pass++;
        tick();
        bus.load_use = 1'b0;
        #1;
        n_total++;
        if (w_ctl !== CTL_IFFL) $display("FAIL pr_jump: ctl=%h want %h", w_ctl, CTL_IFFL);
        else n_pass++;
        tick();
        bus.jump = 1'b0;
        n_total++;
        if (bus.flush_events !== 4'd1 || bus.stall_cycles !== 4'd1)
            $display("FAIL pr_counts: flush=%0d stall=%0d want 1 1",
                     bus.flush_events, bus.stall_cycles);
        else n_pass++;
        bus.load_use = 1'b1;
        repeat (20) tick();
        bus.load_use = 1'b0;
        #1;
        n_total++;
        if (bus.stall_cycles !== 4'd15) $display("FAIL sat_stall: got %0d want 15", bus.stall_cycles);
        else n_pass++;
        n_total++;
        if (w_ctl !== CTL_RUN) $display("FAIL sat_run: ctl=%h want %h", w_ctl, CTL_RUN);
        else n_pass++;
        // Clear and increment together must give 0.
        bus.load_use = 1'b1;
        clr_counters();
        bus.load_use = 1'b0;
        n_total++;
        if (bus.stall_cycles !== 4'd0) $display("FAIL clr_vs_inc: got %0d want 0", bus.stall_cycles);
        else n_pass++;
    endtask

    task automatic test_reset_mid_flush();
        bus.branch_taken = 1'b1;
        tick();
        bus.branch_taken = 1'b0;
        reset = 1'b0;
        #1;
        n_total++;
        if (w_ctl !== CTL_OFF) $display("FAIL rmf_off: ctl=%h want %h", w_ctl, CTL_OFF);
        else n_pass++;
        #1 reset = 1'b1;
        tick();
        n_total++;
        if (w_ctl !== CTL_RUN) $display("FAIL rmf_run: ctl=%h want %h", w_ctl, CTL_RUN);
        else n_pass++;
    endtask

    initial begin
        n_pass           = 0;
        n_total          = 0;
        reset            = 1'b0;
        bus.load_use     = 1'b0;
        bus.jump         = 1'b0;
        bus.branch_taken = 1'b0;
        bus.mem_busy     = 1'b0;
        bus.cnt_clr      = 1'b0;
        test_reset();
        test_load_use();
        test_branch();
        test_branch_restart();
        test_mem_freeze();
        test_watchdog();
        test_priority_sat();
        test_reset_mid_flush();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
